id_stage_pipe: RTL and testbench



---
 rtl/core_pkg.sv | 31 +++
 rtl/reg_file_wt.sv | 41 ++++
 rtl/id_stage_pipe.sv | 244 ++++++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared decode definitions for the in-order core.
// Opcodes, ALU encodings and the ID->EX control bundle.
package core_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [3:0] alu_ctrl;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrc;
        logic       illegal;
    } id_payload_t;

endpackage

// File: rtl/reg_file_wt.sv
// Register file, 2 read / 1 write, write-through, x0 hardwired to 0.
// Writes to indices beyond NREG are dropped.
module reg_file_wt #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] mem [NREG];
    logic            wr_ok;

    assign wr_ok = we && (wa != 5'd0) && (32'(wa) < NREG);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[wa[AW-1:0]] <= wd;
        end
    end

    always_comb begin
        rd1 = mem[ra1[AW-1:0]];
        rd2 = mem[ra2[AW-1:0]];
        if (wr_ok && wa == ra1) rd1 = wd;
        if (wr_ok && wa == ra2) rd2 = wd;
        if (ra1 == 5'd0) rd1 = '0;
        if (ra2 == 5'd0) rd2 = '0;
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: RV32I/E decode, operand forwarding, branch resolution,
// load-use stall and the valid/ready register feeding EX.
module id_stage_pipe
    import core_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NFWD = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_valid_i,
    input  logic [XLEN-1:0]      if_pc_i,
    input  logic [31:0]          if_inst_i,
    input  logic                 if_pred_taken_i,
    output logic                 id_ready_o,
    input  logic                 flush_i,
    input  logic                 ex_ready_i,
    output logic                 ex_valid_o,
    output logic [XLEN-1:0]      ex_pc_o,
    output logic [XLEN-1:0]      ex_op1_o,
    output logic [XLEN-1:0]      ex_op2_o,
    output logic [XLEN-1:0]      ex_imm_o,
    output logic [4:0]           ex_rs1_o,
    output logic [4:0]           ex_rs2_o,
    output logic [4:0]           ex_rd_o,
    output logic [3:0]           ex_alu_ctrl_o,
    output logic                 ex_memread_o,
    output logic                 ex_memwrite_o,
    output logic                 ex_memtoreg_o,
    output logic                 ex_regwrite_o,
    output logic                 ex_alusrc_o,
    output logic                 ex_illegal_o,
    input  logic [NFWD-1:0]      fwd_we_i,
    input  logic [NFWD-1:0]      fwd_is_load_i,
    input  logic [5*NFWD-1:0]    fwd_rd_i,
    input  logic [XLEN*NFWD-1:0] fwd_data_i,
    input  logic                 wb_we_i,
    input  logic [4:0]           wb_rd_i,
    input  logic [XLEN-1:0]      wb_data_i,
    output logic                 redirect_o,
    output logic [XLEN-1:0]      redirect_pc_o
);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [4:0] rs1, rs2, rd;

    assign opc = if_inst_i[6:0];
    assign rd  = if_inst_i[11:7];
    assign f3  = if_inst_i[14:12];
    assign rs1 = if_inst_i[19:15];
    assign rs2 = if_inst_i[24:20];

    logic is_load, is_store, is_op, is_opi, is_br;
    logic is_jal, is_jalr, is_lui, is_auipc;
    logic known, use1, use2, wr_rd, bad_e, illegal;

    assign is_load  = opc == OPC_LOAD;
    assign is_store = opc == OPC_STORE;
    assign is_op    = opc == OPC_OP;
    assign is_opi   = opc == OPC_OP_IMM;
    assign is_br    = opc == OPC_BRANCH;
    assign is_jal   = opc == OPC_JAL;
    assign is_jalr  = opc == OPC_JALR;
    assign is_lui   = opc == OPC_LUI;
    assign is_auipc = opc == OPC_AUIPC;

    assign known = is_load | is_store | is_op | is_opi | is_br
                 | is_jal | is_jalr | is_lui | is_auipc;
    assign use1  = is_load | is_store | is_op | is_opi | is_br | is_jalr;
    assign use2  = is_store | is_op | is_br;
    assign wr_rd = is_load | is_op | is_opi | is_lui
                 | is_auipc | is_jal | is_jalr;

    // RV32E only exposes x0..x15
    assign bad_e = (NREG == 16)
                && ((use1 & rs1[4]) | (use2 & rs2[4]) | (wr_rd & rd[4]));
    assign illegal = ~known | bad_e;

    logic [XLEN-1:0] rf1, rf2;

    reg_file_wt #(.XLEN(XLEN), .NREG(NREG)) u_rf (
        .clk (clk),
        .rst (rst),
        .ra1 (rs1),
        .ra2 (rs2),
        .rd1 (rf1),
        .rd2 (rf2),
        .we  (wb_we_i),
        .wa  (wb_rd_i),
        .wd  (wb_data_i)
    );

    logic [XLEN-1:0] src1, src2;
    logic            haz, hazard;

    // Walk oldest to youngest so the lowest index wins.
    always_comb begin
        src1 = rf1;
        src2 = rf2;
        haz  = 1'b0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_we_i[i] && fwd_rd_i[5*i +: 5] == rs1)
                src1 = fwd_data_i[XLEN*i +: XLEN];
            if (fwd_we_i[i] && fwd_rd_i[5*i +: 5] == rs2)
                src2 = fwd_data_i[XLEN*i +: XLEN];
            if (fwd_we_i[i] && fwd_is_load_i[i]
                && ((use1 && rs1 != 5'd0 && fwd_rd_i[5*i +: 5] == rs1)
                 || (use2 && rs2 != 5'd0 && fwd_rd_i[5*i +: 5] == rs2)))
                haz = 1'b1;
        end
        if (rs1 == 5'd0) src1 = '0;
        if (rs2 == 5'd0) src2 = '0;
    end

    assign hazard = if_valid_i & haz;

    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;

    always_comb begin
        imm32 = '0;
        unique case (1'b1)
            is_load, is_opi, is_jalr:
                imm32 = {{20{if_inst_i[31]}}, if_inst_i[31:20]};
            is_store:
                imm32 = {{20{if_inst_i[31]}}, if_inst_i[31:25],
                         if_inst_i[11:7]};
            is_br:
                imm32 = {{19{if_inst_i[31]}}, if_inst_i[31], if_inst_i[7],
                         if_inst_i[30:25], if_inst_i[11:8], 1'b0};
            is_lui, is_auipc:
                imm32 = {if_inst_i[31:12], 12'b0};
            is_jal:
                imm32 = {{11{if_inst_i[31]}}, if_inst_i[31],
                         if_inst_i[19:12], if_inst_i[20],
                         if_inst_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

    logic taken, acc;

    always_comb begin
        case (f3)
            3'b000:  taken = src1 == src2;
            3'b001:  taken = src1 != src2;
            3'b100:  taken = $signed(src1) < $signed(src2);
            3'b101:  taken = $signed(src1) >= $signed(src2);
            3'b110:  taken = src1 < src2;
            3'b111:  taken = src1 >= src2;
            default: taken = 1'b0;
        endcase
    end

    assign id_ready_o = ~hazard & (ex_ready_i | ~ex_valid_o);
    assign acc        = if_valid_i & id_ready_o & ~flush_i;

    logic [XLEN-1:0] jalr_sum;

    assign jalr_sum   = src1 + imm;
    assign redirect_o = acc & ~illegal
                      & (is_jal | is_jalr
                         | (is_br & (taken ^ if_pred_taken_i)));

    always_comb begin
        if (is_jalr)
            redirect_pc_o = {jalr_sum[XLEN-1:1], 1'b0};
        else if (is_jal || (is_br && taken))
            redirect_pc_o = if_pc_i + imm;
        else
            redirect_pc_o = if_pc_i + XLEN'(4);
    end

    id_payload_t     nxt, cur;
    logic [XLEN-1:0] op1_n, op2_n;

    always_comb begin
        nxt          = '0;
        nxt.rs1      = use1 ? rs1 : 5'd0;
        nxt.rs2      = use2 ? rs2 : 5'd0;
        nxt.rd       = wr_rd ? rd : 5'd0;
        nxt.alu_ctrl = ALU_ADD;
        unique case (1'b1)
            is_op:   nxt.alu_ctrl = {if_inst_i[30], f3};
            is_opi:  nxt.alu_ctrl = {(f3 == 3'b101) & if_inst_i[30], f3};
            is_br:   nxt.alu_ctrl = ALU_SUB;
            default: nxt.alu_ctrl = ALU_ADD;
        endcase
        nxt.memread  = is_load;
        nxt.memtoreg = is_load;
        nxt.memwrite = is_store;
        nxt.regwrite = wr_rd;
        nxt.alusrc   = is_load | is_store | is_opi | is_lui | is_auipc;
        nxt.illegal  = illegal;
        if (illegal) begin
            nxt.memread  = 1'b0;
            nxt.memtoreg = 1'b0;
            nxt.memwrite = 1'b0;
            nxt.regwrite = 1'b0;
            nxt.alusrc   = 1'b0;
        end
        op1_n = use1 ? src1 : '0;
        op2_n = use2 ? src2 : '0;
        if (is_jal || is_jalr || is_auipc) op1_n = if_pc_i;
        if (is_jal || is_jalr) op2_n = XLEN'(4);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_o <= 1'b0;
            ex_pc_o    <= '0;
            ex_op1_o   <= '0;
            ex_op2_o   <= '0;
            ex_imm_o   <= '0;
            cur        <= '0;
        end else if (flush_i) begin
            ex_valid_o <= 1'b0;
        end else if (acc) begin
            ex_valid_o <= 1'b1;
            ex_pc_o    <= if_pc_i;
            ex_op1_o   <= op1_n;
            ex_op2_o   <= op2_n;
            ex_imm_o   <= imm;
            cur        <= nxt;
        end else if (ex_ready_i) begin
            ex_valid_o <= 1'b0;
        end
    end

    assign ex_rs1_o      = cur.rs1;
    assign ex_rs2_o      = cur.rs2;
    assign ex_rd_o       = cur.rd;
    assign ex_alu_ctrl_o = cur.alu_ctrl;
    assign ex_memread_o  = cur.memread;
    assign ex_memwrite_o = cur.memwrite;
    assign ex_memtoreg_o = cur.memtoreg;
    assign ex_regwrite_o = cur.regwrite;
    assign ex_alusrc_o   = cur.alusrc;
    assign ex_illegal_o  = cur.illegal;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: RV32I (XLEN=32) and
// RV32E (XLEN=64, NREG=16) instances with directed vectors.
module tb_id_stage_pipe;
    import core_pkg::*;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] op1;
        logic [63:0] op2;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic        rw;
        logic        mr;
        logic        asrc;
        logic        ill;
    } exp_t;

    int total = 0;
    int bad   = 0;
    exp_t qa[$];
    exp_t qb[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        if_valid, if_pred, flush, ex_ready;
    logic [31:0] if_pc, if_inst;
    logic        id_ready, ex_valid, redirect;
    logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm, redirect_pc;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_alu;
    logic        ex_mr, ex_mw, ex_mtr, ex_rw, ex_asrc, ex_ill;
    logic [1:0]  fwd_we, fwd_ld;
    logic [9:0]  fwd_rd;
    logic [63:0] fwd_data;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    id_stage_pipe #(.XLEN(32), .NREG(32), .NFWD(2)) dut_a (
        .clk(clk), .rst(rst),
        .if_valid_i(if_valid), .if_pc_i(if_pc), .if_inst_i(if_inst),
        .if_pred_taken_i(if_pred), .id_ready_o(id_ready),
        .flush_i(flush), .ex_ready_i(ex_ready), .ex_valid_o(ex_valid),
        .ex_pc_o(ex_pc), .ex_op1_o(ex_op1), .ex_op2_o(ex_op2),
        .ex_imm_o(ex_imm), .ex_rs1_o(ex_rs1), .ex_rs2_o(ex_rs2),
        .ex_rd_o(ex_rd), .ex_alu_ctrl_o(ex_alu),
        .ex_memread_o(ex_mr), .ex_memwrite_o(ex_mw),
        .ex_memtoreg_o(ex_mtr), .ex_regwrite_o(ex_rw),
        .ex_alusrc_o(ex_asrc), .ex_illegal_o(ex_ill),
        .fwd_we_i(fwd_we), .fwd_is_load_i(fwd_ld), .fwd_rd_i(fwd_rd),
        .fwd_data_i(fwd_data), .wb_we_i(wb_we), .wb_rd_i(wb_rd),
        .wb_data_i(wb_data), .redirect_o(redirect),
        .redirect_pc_o(redirect_pc)
    );

    logic         b_valid, b_pred, b_flush, b_ready;
    logic [63:0]  b_pc;
    logic [31:0]  b_inst;
    logic         b_id_ready, b_ex_valid, b_redirect;
    logic [63:0]  b_ex_pc, b_op1, b_op2, b_imm, b_redirect_pc;
    logic [4:0]   b_rs1, b_rs2, b_rd;
    logic [3:0]   b_alu;
    logic         b_mr, b_mw, b_mtr, b_rw, b_asrc, b_ill;
    logic [1:0]   b_fwd_we, b_fwd_ld;
    logic [9:0]   b_fwd_rd;
    logic [127:0] b_fwd_data;
    logic         b_wb_we;
    logic [4:0]   b_wb_rd;
    logic [63:0]  b_wb_data;

    id_stage_pipe #(.XLEN(64), .NREG(16), .NFWD(2)) dut_b (
        .clk(clk), .rst(rst),
        .if_valid_i(b_valid), .if_pc_i(b_pc), .if_inst_i(b_inst),
        .if_pred_taken_i(b_pred), .id_ready_o(b_id_ready),
        .flush_i(b_flush), .ex_ready_i(b_ready), .ex_valid_o(b_ex_valid),
        .ex_pc_o(b_ex_pc), .ex_op1_o(b_op1), .ex_op2_o(b_op2),
        .ex_imm_o(b_imm), .ex_rs1_o(b_rs1), .ex_rs2_o(b_rs2),
        .ex_rd_o(b_rd), .ex_alu_ctrl_o(b_alu),
        .ex_memread_o(b_mr), .ex_memwrite_o(b_mw),
        .ex_memtoreg_o(b_mtr), .ex_regwrite_o(b_rw),
        .ex_alusrc_o(b_asrc), .ex_illegal_o(b_ill),
        .fwd_we_i(b_fwd_we), .fwd_is_load_i(b_fwd_ld),
        .fwd_rd_i(b_fwd_rd), .fwd_data_i(b_fwd_data),
        .wb_we_i(b_wb_we), .wb_rd_i(b_wb_rd), .wb_data_i(b_wb_data),
        .redirect_o(b_redirect), .redirect_pc_o(b_redirect_pc)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(
        input logic [63:0] pc, op1, op2, imm, input logic [4:0] rd,
        input logic [3:0] alu, input logic rw, mr, asrc, ill);
        exp_t e;
        e.pc = pc; e.op1 = op1; e.op2 = op2; e.imm = imm;
        e.rd = rd; e.alu = alu; e.rw = rw; e.mr = mr;
        e.asrc = asrc; e.ill = ill;
        return e;
    endfunction

    task automatic cmp(input string t, input exp_t e, input exp_t a);
        chk({t, "_pc"},  a.pc,  e.pc);
        chk({t, "_op1"}, a.op1, e.op1);
        chk({t, "_op2"}, a.op2, e.op2);
        chk({t, "_imm"}, a.imm, e.imm);
        chk({t, "_rd"},  64'(a.rd),  64'(e.rd));
        chk({t, "_alu"}, 64'(a.alu), 64'(e.alu));
        chk({t, "_ctl"}, 64'({a.rw, a.mr, a.asrc, a.ill}),
                         64'({e.rw, e.mr, e.asrc, e.ill}));
    endtask

    // Monitors: pop one expectation per payload that EX consumes.
    always @(negedge clk) begin
        if (!rst && ex_valid && ex_ready) begin
            if (qa.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_a_extra: got pc %h want none", ex_pc);
            end else begin
                cmp("a", qa.pop_front(),
                    mk(64'(ex_pc), 64'(ex_op1), 64'(ex_op2), 64'(ex_imm),
                       ex_rd, ex_alu, ex_rw, ex_mr, ex_asrc, ex_ill));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_ex_valid && b_ready) begin
            if (qb.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_b_extra: got pc %h want none", b_ex_pc);
            end else begin
                cmp("b", qb.pop_front(),
                    mk(b_ex_pc, b_op1, b_op2, b_imm,
                       b_rd, b_alu, b_rw, b_mr, b_asrc, b_ill));
            end
        end
    end

    function automatic logic [31:0] enc_r(input logic [6:0] f7,
        input logic [4:0] r2, r1, input logic [2:0] f3, input logic [4:0] d);
        return {f7, r2, r1, f3, d, OPC_OP};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] im,
        input logic [4:0] r1, input logic [2:0] f3, input logic [4:0] d,
        input logic [6:0] op);
        return {im, r1, f3, d, op};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] im,
        input logic [4:0] r2, r1, input logic [2:0] f3);
        return {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], OPC_BRANCH};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] im,
        input logic [4:0] d);
        return {im[20], im[10:1], im[11], im[19:12], d, OPC_JAL};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [31:0] pc, inst, input logic pred);
        if_valid = 1'b1; if_pc = pc; if_inst = inst; if_pred = pred;
    endtask

    task automatic bdrv(input logic [63:0] pc, input logic [31:0] inst);
        b_valid = 1'b1; b_pc = pc; b_inst = inst;
    endtask

    initial begin
        if_valid = 0; if_pred = 0; if_pc = 0; if_inst = 0;
        flush = 0; ex_ready = 1;
        fwd_we = 0; fwd_ld = 0; fwd_rd = 0; fwd_data = 0;
        wb_we = 0; wb_rd = 0; wb_data = 0;
        b_valid = 0; b_pred = 0; b_pc = 0; b_inst = 0;
        b_flush = 0; b_ready = 1;
        b_fwd_we = 0; b_fwd_ld = 0; b_fwd_rd = 0; b_fwd_data = 0;
        b_wb_we = 0; b_wb_rd = 0; b_wb_data = 0;

        #2;
        chk("rst_valid", 64'(ex_valid), 64'd0);
        chk("rst_pc", 64'(ex_pc), 64'd0);
        chk("rst_op1", 64'(ex_op1), 64'd0);
        chk("rst_b_valid", 64'(b_ex_valid), 64'd0);
        #10 rst = 0;
        tick();

        // write-through and register file contents
        wb_we = 1; wb_rd = 5; wb_data = 32'h11;
        drv(32'h40, enc_r(7'h00, 5'd0, 5'd5, 3'b000, 5'd6), 0);
        qa.push_back(mk(32'h40, 32'h11, 0, 0, 6, 4'h0, 1, 0, 0, 0));
        tick();
        wb_we = 0;
        drv(32'h44, enc_r(7'h00, 5'd5, 5'd5, 3'b000, 5'd10), 0);
        qa.push_back(mk(32'h44, 32'h11, 32'h11, 0, 10, 4'h0, 1, 0, 0, 0));
        tick();
        drv(32'h48, enc_r(7'h20, 5'd0, 5'd5, 3'b000, 5'd12), 0);
        qa.push_back(mk(32'h48, 32'h11, 0, 0, 12, 4'h8, 1, 0, 0, 0));
        tick();

        // forwarding priority: entry 0 beats entry 1
        fwd_we = 2'b11; fwd_rd = {5'd7, 5'd7};
        fwd_data = {32'hBB, 32'hAA};
        drv(32'h200, enc_b(13'd8, 5'd0, 5'd7, 3'b000), 0);
        qa.push_back(mk(32'h200, 32'hAA, 0, 8, 0, 4'h8, 0, 0, 0, 0));
        @(negedge clk);
        chk("beq_fwd_redir", 64'(redirect), 64'd0);
        tick();
        drv(32'h204, enc_b(13'd8, 5'd0, 5'd7, 3'b001), 0);
        qa.push_back(mk(32'h204, 32'hAA, 0, 8, 0, 4'h8, 0, 0, 0, 0));
        @(negedge clk);
        chk("bne_redir", 64'(redirect), 64'd1);
        chk("bne_target", 64'(redirect_pc), 64'h20C);
        tick();
        fwd_we = 2'b10;
        drv(32'h208, enc_r(7'h00, 5'd0, 5'd7, 3'b000, 5'd11), 0);
        qa.push_back(mk(32'h208, 32'hBB, 0, 0, 11, 4'h0, 1, 0, 0, 0));
        tick();

        // signed vs unsigned compare with -1
        fwd_we = 2'b01; fwd_rd = {5'd0, 5'd3};
        fwd_data = {32'h0, 32'hFFFF_FFFF};
        drv(32'h300, enc_b(13'd16, 5'd0, 5'd3, 3'b100), 0);
        qa.push_back(mk(32'h300, 32'hFFFF_FFFF, 0, 16, 0, 4'h8, 0, 0, 0, 0));
        @(negedge clk);
        chk("blt_redir", 64'(redirect), 64'd1);
        chk("blt_target", 64'(redirect_pc), 64'h310);
        tick();
        drv(32'h304, enc_b(13'd16, 5'd0, 5'd3, 3'b110), 0);
        qa.push_back(mk(32'h304, 32'hFFFF_FFFF, 0, 16, 0, 4'h8, 0, 0, 0, 0));
        @(negedge clk);
        chk("bltu_redir", 64'(redirect), 64'd0);
        tick();
        fwd_we = 0;

        // misprediction in both directions
        drv(32'h100, enc_b(13'd16, 5'd1, 5'd1, 3'b000), 0);
        qa.push_back(mk(32'h100, 0, 0, 16, 0, 4'h8, 0, 0, 0, 0));
        @(negedge clk);
        chk("beq_p0_redir", 64'(redirect), 64'd1);
        chk("beq_p0_target", 64'(redirect_pc), 64'h110);
        tick();
        drv(32'h100, enc_b(13'd16, 5'd1, 5'd1, 3'b000), 1);
        qa.push_back(mk(32'h100, 0, 0, 16, 0, 4'h8, 0, 0, 0, 0));
        @(negedge clk);
        chk("beq_p1_redir", 64'(redirect), 64'd0);
        tick();

        // load-use: one bubble, then forwarded data
        fwd_we = 2'b01; fwd_ld = 2'b01; fwd_rd = {5'd0, 5'd8};
        drv(32'h500, enc_i(12'd1, 5'd8, 3'b000, 5'd9, OPC_OP_IMM), 0);
        @(negedge clk);
        chk("lu_ready", 64'(id_ready), 64'd0);
        tick();
        fwd_ld = 2'b00; fwd_data = {32'h0, 32'h40};
        qa.push_back(mk(32'h500, 32'h40, 0, 1, 9, 4'h0, 1, 0, 1, 0));
        @(negedge clk);
        chk("lu_bubble", 64'(ex_valid), 64'd0);
        chk("lu_ready2", 64'(id_ready), 64'd1);
        tick();
        fwd_we = 0;

        // jalr and jal, including pc wrap
        if_valid = 0;
        wb_we = 1; wb_rd = 2; wb_data = 32'h200;
        tick();
        wb_we = 0;
        drv(32'h300, enc_i(12'd3, 5'd2, 3'b000, 5'd1, OPC_JALR), 0);
        qa.push_back(mk(32'h300, 32'h300, 4, 3, 1, 4'h0, 1, 0, 0, 0));
        @(negedge clk);
        chk("jalr_redir", 64'(redirect), 64'd1);
        chk("jalr_target", 64'(redirect_pc), 64'h202);
        tick();
        drv(32'hFFFF_FFF0, enc_j(21'h20, 5'd1), 0);
        qa.push_back(mk(32'hFFFF_FFF0, 32'hFFFF_FFF0, 4, 32'h20, 1, 4'h0,
                        1, 0, 0, 0));
        @(negedge clk);
        chk("jal_wrap_target", 64'(redirect_pc), 64'h10);
        tick();
        drv(32'h600, 32'hFFFF_FFFF, 0);
        qa.push_back(mk(32'h600, 0, 0, 0, 0, 4'h0, 0, 0, 0, 1));
        @(negedge clk);
        chk("ill_redir", 64'(redirect), 64'd0);
        tick();
        if_valid = 0;
        tick();

        // flush beats accept, and kills a stalled payload
        ex_ready = 0; flush = 1;
        drv(32'h704, enc_j(21'h8, 5'd1), 0);
        @(negedge clk);
        chk("fl_ready", 64'(id_ready), 64'd1);
        chk("fl_redir", 64'(redirect), 64'd0);
        tick();
        flush = 0; if_valid = 0;
        @(negedge clk);
        chk("fl_valid", 64'(ex_valid), 64'd0);
        tick();
        drv(32'h700, enc_i(12'd5, 5'd0, 3'b000, 5'd13, OPC_OP_IMM), 0);
        tick();
        if_valid = 0;
        chk("stall_v1", 64'(ex_valid), 64'd1);
        chk("stall_pc1", 64'(ex_pc), 64'h700);
        tick();
        chk("stall_pc2", 64'(ex_pc), 64'h700);
        chk("stall_imm2", 64'(ex_imm), 64'd5);
        flush = 1;
        tick();
        flush = 0;
        chk("fl_kill", 64'(ex_valid), 64'd0);

        // asynchronous reset in the middle of a stall
        drv(32'h800, enc_i(12'd7, 5'd0, 3'b000, 5'd14, OPC_OP_IMM), 0);
        tick();
        if_valid = 0;
        chk("ar_before", 64'(ex_valid), 64'd1);
        #2 rst = 1;
        #1;
        chk("ar_valid", 64'(ex_valid), 64'd0);
        chk("ar_pc", 64'(ex_pc), 64'd0);
        #2 rst = 0;
        ex_ready = 1;
        tick();
        drv(32'h44, enc_r(7'h00, 5'd5, 5'd5, 3'b000, 5'd10), 0);
        qa.push_back(mk(32'h44, 0, 0, 0, 10, 4'h0, 1, 0, 0, 0));
        tick();
        if_valid = 0;
        tick();

        // RV32E / XLEN=64 instance
        bdrv(64'h1000, enc_i(12'd1, 5'd0, 3'b000, 5'd20, OPC_OP_IMM));
        qb.push_back(mk(64'h1000, 0, 0, 1, 20, 4'h0, 0, 0, 0, 1));
        tick();
        bdrv(64'h2000, enc_j(21'h8, 5'd20));
        qb.push_back(mk(64'h2000, 64'h2000, 4, 8, 20, 4'h0, 0, 0, 0, 1));
        @(negedge clk);
        chk("b_ill_jal_redir", 64'(b_redirect), 64'd0);
        tick();
        bdrv(64'h2004, enc_i(12'hFFF, 5'd0, 3'b000, 5'd1, OPC_OP_IMM));
        qb.push_back(mk(64'h2004, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 4'h0,
                        1, 0, 1, 0));
        tick();
        bdrv(64'h2008, {20'h80000, 5'd1, OPC_LUI});
        qb.push_back(mk(64'h2008, 0, 0, 64'hFFFF_FFFF_8000_0000, 1, 4'h0,
                        1, 0, 1, 0));
        tick();
        bdrv(64'h0, enc_j(21'h1F_FFF8, 5'd1));
        qb.push_back(mk(64'h0, 0, 4, 64'hFFFF_FFFF_FFFF_FFF8, 1, 4'h0,
                        1, 0, 0, 0));
        @(negedge clk);
        chk("b_jal_redir", 64'(b_redirect), 64'd1);
        chk("b_jal_wrap", b_redirect_pc, 64'hFFFF_FFFF_FFFF_FFF8);
        tick();
        b_valid = 0;
        tick();
        tick();

        chk("sb_a_left", 64'(qa.size()), 64'd0);
        chk("sb_b_left", 64'(qb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
